e_mdu: RTL

Multi-cycle multiply/divide unit in the Execute stage. It takes operands from the D/E pipeline register outputs (forwarded rs/rt values) and produces the architectural HI/LO registers. It exports a busy flag that the hazard unit uses to stall the D stage while an MD operation is in flight.

---
 rtl/e_mdu_pkg.sv | 26 ++
 rtl/e_mdu_compute.sv | 47 ++++
 rtl/e_mdu.sv | 101 ++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MD op encodings and FSM state type for the E-stage multiply/divide unit.
// Also used by the controller that drives MDopE.
package e_mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_compute.sv
// Combinational datapath: maps A, B and op to a 64-bit {hi,lo} result.
// Signed division is done on magnitudes through one shared divider.
module mdu_compute
    import e_mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        sgn_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        a_ext = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        product = a_ext * b_ext;

        sgn_div     = (op == MD_DIV);
        div_by_zero = md_is_div(op) && (b == '0);
        dividend    = (sgn_div && a[31]) ? (~a + 32'd1) : a;
        divisor     = (sgn_div && b[31]) ? (~b + 32'd1) : b;
        if (divisor == '0) begin
            divisor = 32'd1;
        end
        q_mag = dividend / divisor;
        r_mag = dividend % divisor;

        result = '0;
        if (md_is_div(op)) begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            result[31:0]  = (sgn_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
            result[63:32] = (sgn_div && a[31]) ? (~r_mag + 32'd1) : r_mag;
        end else begin
            result = product;
        end
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit: holds HI/LO, the pending result
// and the busy countdown that the hazard unit uses to stall D.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDopE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    mdu_state_e  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0] pend, pend_n;
    logic        pend_dz, pend_dz_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic [63:0] res;
    logic        res_dz;

    mdu_compute u_compute (
        .a           (A),
        .b           (B),
        .op          (MDopE),
        .result      (res),
        .div_by_zero (res_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            pend_dz <= pend_dz_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend;
        pend_dz_n = pend_dz;
        hi_n      = hi_q;
        lo_n      = lo_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (md_is_long(MDopE)) begin
                        pend_n    = res;
                        pend_dz_n = res_dz;
                        cnt_n     = md_is_div(MDopE) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_n   = S_RUN;
                    end else if (MDopE == MD_MTHI) begin
                        hi_n = A;
                    end else if (MDopE == MD_MTLO) begin
                        lo_n = A;
                    end
                end
            end
            S_RUN: begin
                // Counter reaches 1 on the edge before completion, so busy spans exactly N cycles.
                if (cnt == CW'(1)) begin
                    if (!pend_dz) begin
                        hi_n = pend[63:32];
                        lo_n = pend[31:0];
                    end
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
